// File: rtl/repl_pkg.sv
// Shared types and helpers for the replacement policy unit and its victim selector.
package repl_pkg;

  localparam int DEF_AGE_W = 16;
  // Widest age counter sat_inc can handle.
  localparam int AGE_MAX_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } repl_state_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_AGE_W-1:0] age;
  } line_meta_t;

  // Increment that sticks at 2**width-1.
  function automatic logic [AGE_MAX_W-1:0] sat_inc(input logic [AGE_MAX_W-1:0] val,
                                                   input int unsigned          width);
    logic [AGE_MAX_W-1:0] top;
    if (width >= AGE_MAX_W) top = '1;
    else top = (AGE_MAX_W'(1) << width) - AGE_MAX_W'(1);
    return (val >= top) ? top : val + AGE_MAX_W'(1);
  endfunction

endpackage

// File: rtl/repl_victim_select.sv
// Combinational victim choice for one set: lowest invalid way, else oldest way
// with ties resolved toward the lowest index.
module repl_victim_select #(
  parameter int N_WAYS = 2,
  parameter int N_POW  = 4,
  parameter int AGE_W  = 16
) (
  input  logic [N_WAYS-1:0] valid_i,
  input  logic [AGE_W-1:0]  age_i [N_WAYS],
  output logic [N_POW-1:0]  way_o,
  output logic              empty_o
);

  logic [AGE_W-1:0] best_age;
  logic [N_POW-1:0] best_way;

  always_comb begin
    best_age = age_i[0];
    best_way = '0;
    for (int w = 1; w < N_WAYS; w++) begin
      if (age_i[w] > best_age) begin
        best_age = age_i[w];
        best_way = N_POW'(w);
      end
    end
    way_o   = best_way;
    empty_o = 1'b0;
    // Descending scan so the lowest invalid way is the one that sticks.
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        way_o   = N_POW'(w);
        empty_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/replacement_policy_unit.sv
// Multi-set LRU-by-age replacement state with victim query handshake and flush walk.
// Optional REPL_STATS_EN adds eviction / empty-fill counters.
//
// state | meaning
// IDLE  | normal operation: touches, invalidates and queries accepted
// FLUSH | clearing one set per cycle; queries stalled, touch/inv dropped
module replacement_policy_unit
  import repl_pkg::*;
#(
  parameter int N_WAYS   = 2,
  parameter int N_POW    = 4,
  parameter int N_SETS   = 16,
  parameter int SET_BITS = 4,
  parameter int AGE_W    = DEF_AGE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  output logic                flush_busy_o,
  input  logic                touch_valid_i,
  input  logic [SET_BITS-1:0] touch_set_i,
  input  logic [N_POW-1:0]    touch_way_i,
  input  logic                inv_valid_i,
  input  logic [SET_BITS-1:0] inv_set_i,
  input  logic [N_POW-1:0]    inv_way_i,
  input  logic                query_valid_i,
  input  logic [SET_BITS-1:0] query_set_i,
  output logic                query_ready_o,
`ifdef REPL_STATS_EN
  output logic [31:0]         evict_cnt_o,
  output logic [31:0]         fill_empty_cnt_o,
`endif
  output logic                victim_valid_o,
  output logic [N_POW-1:0]    victim_way_o,
  output logic                victim_empty_o
);

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_FLUSH = FLUSH;
  localparam logic [N_POW:0]   WAYS_LIM = (N_POW + 1)'(N_WAYS);
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(N_SETS - 1);

  logic [0:0]          state_q;
  logic [SET_BITS-1:0] flush_idx_q;

  logic [N_WAYS-1:0]   valid_q [N_SETS];
  logic [AGE_W-1:0]    age_q   [N_SETS][N_WAYS];
  logic [N_WAYS-1:0]   valid_d [N_SETS];
  logic [AGE_W-1:0]    age_d   [N_SETS][N_WAYS];

  logic                in_flush;
  logic                touch_en;
  logic                inv_en;
  logic                query_acc;
  logic [AGE_W-1:0]    q_age [N_WAYS];
  logic [N_POW-1:0]    sel_way;
  logic                sel_empty;

  assign in_flush      = (state_q == ST_FLUSH);
  assign flush_busy_o  = in_flush;
  assign query_ready_o = !in_flush;
  assign query_acc     = query_valid_i && !in_flush;
  // Out-of-range ways are silently dropped.
  assign touch_en      = touch_valid_i && !in_flush && ({1'b0, touch_way_i} < WAYS_LIM);
  assign inv_en        = inv_valid_i && !in_flush && ({1'b0, inv_way_i} < WAYS_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
          end
        end
        ST_FLUSH: begin
          flush_idx_q <= flush_idx_q + 1'b1;
          if (flush_idx_q == LAST_SET) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Touch is applied first, then invalidate, so an invalidate of the touched
  // line wins and an invalidated neighbour ends with age 0.
  always_comb begin
    for (int s = 0; s < N_SETS; s++) begin
      valid_d[s] = valid_q[s];
      for (int w = 0; w < N_WAYS; w++) age_d[s][w] = age_q[s][w];
    end
    if (in_flush) begin
      valid_d[flush_idx_q] = '0;
      for (int w = 0; w < N_WAYS; w++) age_d[flush_idx_q][w] = '0;
    end else begin
      if (touch_en) begin
        for (int w = 0; w < N_WAYS; w++) begin
          if (touch_way_i == N_POW'(w)) begin
            valid_d[touch_set_i][w] = 1'b1;
            age_d[touch_set_i][w]   = '0;
          end else if (valid_q[touch_set_i][w]) begin
            age_d[touch_set_i][w] =
              AGE_W'(sat_inc(AGE_MAX_W'(age_q[touch_set_i][w]), unsigned'(AGE_W)));
          end
        end
      end
      if (inv_en) begin
        for (int w = 0; w < N_WAYS; w++) begin
          if (inv_way_i == N_POW'(w)) begin
            valid_d[inv_set_i][w] = 1'b0;
            age_d[inv_set_i][w]   = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < N_WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= valid_d[s];
        for (int w = 0; w < N_WAYS; w++) age_q[s][w] <= age_d[s][w];
      end
    end
  end

  // Victim is chosen from the registered state, before this cycle's updates.
  always_comb begin
    for (int w = 0; w < N_WAYS; w++) q_age[w] = age_q[query_set_i][w];
  end

  repl_victim_select #(
    .N_WAYS (N_WAYS),
    .N_POW  (N_POW),
    .AGE_W  (AGE_W)
  ) u_victim_select (
    .valid_i (valid_q[query_set_i]),
    .age_i   (q_age),
    .way_o   (sel_way),
    .empty_o (sel_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
      victim_empty_o <= 1'b0;
    end else begin
      victim_valid_o <= query_acc;
      if (query_acc) begin
        victim_way_o   <= sel_way;
        victim_empty_o <= sel_empty;
      end
    end
  end

`ifdef REPL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      evict_cnt_o      <= '0;
      fill_empty_cnt_o <= '0;
    end else if (query_acc) begin
      if (sel_empty) fill_empty_cnt_o <= fill_empty_cnt_o + 32'd1;
      else           evict_cnt_o      <= evict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/replacement_policy_unit.md
Name: replacement_policy_unit

Overview:
Stateful, multi-set successor to the combinational victim selector. It holds per-set, per-way valid bits and age counters and updates them on cache touches and invalidates. Victim queries use a valid/ready handshake. Sits beside the tag array in the cache controller; the miss handler queries it before every fill.

Parameters:
N_WAYS, 2, associativity (ways per set), must be >= 2
N_POW, 4, width of way index outputs, 2**N_POW >= N_WAYS
N_SETS, 16, number of sets, power of two
SET_BITS, 4, set index width, 2**SET_BITS == N_SETS
AGE_W, 16, width of each saturating age counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  pulse: start invalidate-all walk
flush_busy_o  out  1  high while flush walk in progress
touch_valid_i  in  1  access/fill to (touch_set_i, touch_way_i)
touch_set_i  in  SET_BITS  set of touch
touch_way_i  in  N_POW  way of touch
inv_valid_i  in  1  invalidate single line
inv_set_i  in  SET_BITS  set of invalidate
inv_way_i  in  N_POW  way of invalidate
query_valid_i  in  1  victim request
query_set_i  in  SET_BITS  set to choose victim in
query_ready_o  out  1  request accepted when valid&ready
victim_valid_o  out  1  one-cycle pulse, result valid
victim_way_o  out  N_POW  chosen way
victim_empty_o  out  1  chosen way was invalid (no eviction needed)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all valid=0, all ages=0. Outputs: flush_busy_o=0, query_ready_o=1, victim_valid_o=0, victim_way_o=0, victim_empty_o=0. FSM goes to IDLE.
- FSM IDLE -> FLUSH on flush_i. In FLUSH, one set is cleared per cycle, set index 0..N_SETS-1, taking N_SETS cycles. After the last set, return to IDLE. flush_i during FLUSH is ignored; the walk does not restart.
- In FLUSH: query_ready_o=0, flush_busy_o=1, and touch/inv are ignored.
- A reset asserted mid-flush aborts the walk and applies the reset state.
- Touch on set S, way W: valid[S][W]=1 and age[S][W]=0. Every other valid way in S increments its age, saturating at 2**AGE_W-1. Invalid ways keep age 0. Other sets are unchanged.
- Invalidate: valid=0 and age=0 for that line.
- Same set and way touched and invalidated in the same cycle: invalidate wins.
- Same set, different ways, touched and invalidated in the same cycle: apply both. The invalidated way is not aged.
- touch_way_i or inv_way_i >= N_WAYS: the operation is ignored.
- Query accepted in cycle N; result registered with victim_valid_o high in cycle N+1. Full throughput: one query per cycle.
- Victim selection uses the state before any touch or invalidate in the same cycle N:
  - Lowest-index invalid way gives victim_empty_o=1.
  - Otherwise, the way with the largest age; ties go to the lowest index. victim_empty_o=0.
- The block never updates state on a query; the controller issues a touch when it fills.
- When not in FLUSH, query_ready_o=1.

Optional Feature:
Macro REPL_STATS_EN.
- Defined: adds outputs evict_cnt_o[31:0] (accepted queries with victim_empty_o=0) and fill_empty_cnt_o[31:0] (accepted queries with victim_empty_o=1). Both counters wrap at 2**32, clear on rst, and are unaffected by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package repl_pkg holds:
  - typedef repl_state_e {IDLE, FLUSH};
  - typedef line_meta_t {logic valid; logic [AGE_W-1:0] age;} (parametrised via a package localparam default of 16);
  - function for saturating increment.
- Sub-module repl_victim_select: purely combinational. Takes one set's valid/age vectors and returns way + empty flag. It is reusable by the future tag-pipeline lookahead.

Test Plan:
- After rst, query set 3 -> next cycle victim_valid_o=1, way=0, empty=1.
- Touch set 5 ways 0, then 1 (N_WAYS=2), then query set 5 -> way=0, empty=0 (age 1 vs 0).
- Saturation, with AGE_W=2: touch way 1 five times after a single touch of way 0 -> age[0] stays 3; query returns way 0.
- Same-cycle touch and query on set 2 (way 0 previously invalid) -> query reports way 0 empty=1 (pre-touch state); a following query reports way 1 empty=1.
- flush_i with all lines valid -> flush_busy_o high exactly 16 cycles and query_ready_o low throughout. A touch issued mid-flush is ignored. Queries afterward return empty=1 for every set.
- Touch and invalidate of set 1 way 0 in the same cycle -> line invalid, query gives way 0 empty=1.
- With REPL_STATS_EN defined: 3 empty queries and 2 full queries -> fill_empty_cnt_o=3, evict_cnt_o=2. Reset -> both counters 0.
